// File: rtl/mdu_if.sv
// Bundle between the E-stage/hazard logic and the multiply/divide sequencer.
// The pipeline side is the master; the sequencer is the slave.
interface mdu_if;
  // Handshake: issue acts as valid and !busy acts as ready. An operation
  // fires (start=1) only in a cycle where issue, a valid mul_op and !busy
  // all hold. Nothing offered while busy is accepted or remembered.
  logic        issue;
  logic [2:0]  mul_op;
  logic [1:0]  mthilo;
  logic [1:0]  mfhilo;
  logic [31:0] a;
  logic [31:0] b;
  logic        d_uses_hilo;

  logic        start;
  logic        busy;
  logic        stall_req;
  logic [31:0] hilo_out;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output issue, mul_op, mthilo, mfhilo, a, b, d_uses_hilo,
    input  start, busy, stall_req, hilo_out, hi, lo
  );

  modport slave (
    input  issue, mul_op, mthilo, mfhilo, a, b, d_uses_hilo,
    output start, busy, stall_req, hilo_out, hi, lo
  );
endinterface

// File: rtl/mdu_sequencer.sv
// Multi-cycle MULT/DIV sequencer owning the architectural HI/LO pair.
// Results are computed at issue, held in pend_hi/pend_lo and committed when the countdown expires.
module mdu_sequencer #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic clk,
  input  logic reset,
  mdu_if.slave bus,
  output logic dbg_state
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW_RAW     = $clog2(MAX_CYCLES + 1);
  localparam int CW         = (CW_RAW < 4) ? 4 : CW_RAW;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_t;

  state_t        state, state_n;
  logic [CW-1:0] count, count_n;
  logic [31:0]   hi_q, hi_n;
  logic [31:0]   lo_q, lo_n;
  logic [31:0]   pend_hi, pend_hi_n;
  logic [31:0]   pend_lo, pend_lo_n;

  logic op_valid;
  logic mt_valid;
  logic is_div;
  logic is_signed;
  logic start_w;

  assign op_valid  = ~bus.mul_op[2];
  assign mt_valid  = ~bus.mthilo[1];
  assign is_div    = bus.mul_op[1];
  assign is_signed = bus.mul_op[0];
  assign start_w   = bus.issue & op_valid & (state == S_IDLE);

  // ---------------------------------------------------------------------------
  // Result datapath: only feeds pend_* registers, never an output directly.
  // ---------------------------------------------------------------------------
  logic signed [63:0] prod_s;
  logic [63:0]        prod_u;
  logic               b_zero;
  logic               a_neg;
  logic               b_neg;
  logic [31:0]        a_mag;
  logic [31:0]        b_mag;
  logic [31:0]        div_a;
  logic [31:0]        div_b;
  logic [31:0]        uq;
  logic [31:0]        ur;
  logic [31:0]        res_hi;
  logic [31:0]        res_lo;

  always_comb begin
    prod_s = $signed(bus.a) * $signed(bus.b);
    prod_u = {32'd0, bus.a} * {32'd0, bus.b};
  end

  // Signed division runs on magnitudes so 0x80000000 / -1 falls out as
  // quotient 0x80000000, remainder 0 without a special case.
  always_comb begin
    b_zero = (bus.b == 32'd0);
    a_neg  = is_signed & bus.a[31];
    b_neg  = is_signed & bus.b[31];
    a_mag  = a_neg ? (32'd0 - bus.a) : bus.a;
    b_mag  = b_neg ? (32'd0 - bus.b) : bus.b;
    div_a  = a_mag;
    div_b  = b_zero ? 32'd1 : b_mag;
    uq     = div_a / div_b;
    ur     = div_a % div_b;
  end

  always_comb begin
    res_hi = hi_q;
    res_lo = lo_q;
    if (!is_div) begin
      if (is_signed) begin
        res_hi = prod_s[63:32];
        res_lo = prod_s[31:0];
      end else begin
        res_hi = prod_u[63:32];
        res_lo = prod_u[31:0];
      end
    end else if (!b_zero) begin
      res_lo = (a_neg ^ b_neg) ? (32'd0 - uq) : uq;
      res_hi = a_neg ? (32'd0 - ur) : ur;
    end
  end

  // ---------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_IDLE;
      count   <= '0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      pend_hi <= 32'd0;
      pend_lo <= 32'd0;
    end else begin
      state   <= state_n;
      count   <= count_n;
      hi_q    <= hi_n;
      lo_q    <= lo_n;
      pend_hi <= pend_hi_n;
      pend_lo <= pend_lo_n;
    end
  end

  always_comb begin
    state_n   = state;
    count_n   = count;
    hi_n      = hi_q;
    lo_n      = lo_q;
    pend_hi_n = pend_hi;
    pend_lo_n = pend_lo;
    case (state)
      S_IDLE: begin
        if (start_w) begin
          pend_hi_n = res_hi;
          pend_lo_n = res_lo;
          count_n   = is_div ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
          state_n   = S_BUSY;
        end else if (bus.issue && mt_valid) begin
          if (bus.mthilo[0]) hi_n = bus.a;
          else               lo_n = bus.a;
        end
      end
      S_BUSY: begin
        count_n = count - CW'(1);
        // Commit on the edge where the countdown leaves 1.
        if (count <= CW'(1)) begin
          count_n = '0;
          hi_n    = pend_hi;
          lo_n    = pend_lo;
          state_n = S_IDLE;
        end
      end
      default: begin
        state_n = S_IDLE;
        count_n = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  logic [31:0] hilo_sel;

  always_comb begin
    hilo_sel = 32'd0;
    case (bus.mfhilo)
      2'b10:   hilo_sel = hi_q;
      2'b01:   hilo_sel = lo_q;
      default: hilo_sel = 32'd0;
    endcase
  end

  assign bus.start     = start_w;
  assign bus.busy      = (state == S_BUSY);
  assign bus.stall_req = ((state == S_BUSY) | start_w) & bus.d_uses_hilo;
  assign bus.hilo_out  = hilo_sel;
  assign bus.hi        = hi_q;
  assign bus.lo        = lo_q;
  assign dbg_state     = state;

endmodule

// File: tb/tb_mdu_sequencer.sv
// Randomized plus directed bench for mdu_sequencer: a cycle-level reference
// model feeds an expected queue that a negedge monitor drains and compares.
module tb_mdu_sequencer;

  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  mdu_if bus();
  logic  dbg_state;

  mdu_sequencer #(
    .MULT_CYCLES(MULT_N),
    .DIV_CYCLES (DIV_N)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus),
    .dbg_state(dbg_state)
  );

  // ---------------------------------------------------------------------------
  // Reference model state and scoreboard
  // ---------------------------------------------------------------------------
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;
  bit          p_valid = 1'b0;
  int          p_due = 0;
  logic [31:0] p_hi, p_lo;
  int          busy_from = 0;
  int          free_at = 0;
  bit          mon_en = 1'b0;

  // Entry: {due cycle, expected hi, expected lo}
  logic [95:0] exp_q[$];

  int checks = 0;
  int errors = 0;

  function automatic bit exp_busy(int c);
    return (c >= busy_from) && (c < free_at);
  endfunction

  // {hi, lo} result of a mult/div written with plain 64-bit arithmetic.
  function automatic logic [63:0] ref_result(logic [2:0] op, logic [31:0] x, logic [31:0] y,
                                             logic [31:0] cur_hi, logic [31:0] cur_lo);
    longint          sx, sy, sq, sr;
    longint unsigned ux, uy, up;
    logic [63:0]     res;
    sx = $signed(x);
    sy = $signed(y);
    ux = 64'(x);
    uy = 64'(y);
    res = {cur_hi, cur_lo};
    case (op[1:0])
      2'b00: begin
        up  = ux * uy;
        res = up;
      end
      2'b01: res = sx * sy;
      2'b10: if (y != 32'd0) res = {32'(ux % uy), 32'(ux / uy)};
      default: if (y != 32'd0) begin
        sq  = sx / sy;
        sr  = sx % sy;
        res = {sr[31:0], sq[31:0]};
      end
    endcase
    return res;
  endfunction

  task automatic check1(string name, logic act, logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %b expected %b", name, cyc, act, exp);
    end
  endtask

  task automatic check32(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic step();
    @(posedge clk);
    #1;
    if (p_valid && cyc == p_due) begin
      m_hi    = p_hi;
      m_lo    = p_lo;
      p_valid = 1'b0;
    end
  endtask

  task automatic drive(bit iss, logic [2:0] op, logic [1:0] mt, logic [1:0] mf,
                       logic [31:0] aa, logic [31:0] bb, bit du);
    int          n;
    logic [63:0] r;
    bus.issue       = iss;
    bus.mul_op      = op;
    bus.mthilo      = mt;
    bus.mfhilo      = mf;
    bus.a           = aa;
    bus.b           = bb;
    bus.d_uses_hilo = du;
    if (iss && !op[2] && !exp_busy(cyc)) begin
      n         = op[1] ? DIV_N : MULT_N;
      r         = ref_result(op, aa, bb, m_hi, m_lo);
      busy_from = cyc + 1;
      free_at   = cyc + n + 1;
      p_valid   = 1'b1;
      p_due     = free_at;
      p_hi      = r[63:32];
      p_lo      = r[31:0];
      exp_q.push_back({32'(free_at), r});
    end else if (iss && !mt[1] && !exp_busy(cyc)) begin
      p_valid = 1'b1;
      p_due   = cyc + 1;
      p_hi    = mt[0] ? aa : m_hi;
      p_lo    = mt[0] ? m_lo : aa;
      exp_q.push_back({32'(cyc + 1), p_hi, p_lo});
    end
    step();
  endtask

  task automatic idle(int n, bit du);
    repeat (n) drive(1'b0, 3'd4, 2'd2, 2'd0, 32'd0, 32'd0, du);
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    bus.issue = 1'b0;
    exp_q.delete();
    p_valid = 1'b1;
    p_due   = cyc + 1;
    p_hi    = 32'd0;
    p_lo    = 32'd0;
    if (free_at > cyc + 1) free_at = cyc + 1;
    exp_q.push_back({32'(cyc + 1), 64'd0});
    step();
    reset = 1'b0;
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  // ---------------------------------------------------------------------------
  // Monitor: compares every cycle away from the active edge
  // ---------------------------------------------------------------------------
  always @(negedge clk) begin
    logic        eb, es;
    logic [31:0] eh;
    logic [95:0] head;
    if (mon_en) begin
      eb = exp_busy(cyc);
      es = bus.issue && !bus.mul_op[2] && !eb;
      check1("busy", bus.busy, eb);
      check1("dbg_state", dbg_state, eb);
      check1("start", bus.start, es);
      check1("stall_req", bus.stall_req, (eb || es) && bus.d_uses_hilo);
      case (bus.mfhilo)
        2'b10:   eh = m_hi;
        2'b01:   eh = m_lo;
        default: eh = 32'd0;
      endcase
      check32("hilo_out", bus.hilo_out, eh);
      check32("hi_arch", bus.hi, m_hi);
      check32("lo_arch", bus.lo, m_lo);
      if (exp_q.size() > 0) begin
        head = exp_q[0];
        if (int'(head[95:64]) == cyc) begin
          void'(exp_q.pop_front());
          check32("commit_hi", bus.hi, head[63:32]);
          check32("commit_lo", bus.lo, head[31:0]);
        end else if (int'(head[95:64]) < cyc) begin
          void'(exp_q.pop_front());
          checks++;
          errors++;
          $display("FAIL commit_missed cycle %0d: got none expected due %0d", cyc, int'(head[95:64]));
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    reset           = 1'b1;
    bus.issue       = 1'b0;
    bus.mul_op      = 3'd4;
    bus.mthilo      = 2'd2;
    bus.mfhilo      = 2'd0;
    bus.a           = 32'd0;
    bus.b           = 32'd0;
    bus.d_uses_hilo = 1'b0;
    @(posedge clk);
    #1;
    do_reset();
    mon_en = 1'b1;
    idle(2, 1'b0);

    // MULT with a second MULT offered while busy, hazard consumer present in D.
    drive(1'b1, 3'd1, 2'd2, 2'd0, 32'hFFFF_FFFD, 32'd5, 1'b1);
    idle(1, 1'b1);
    drive(1'b1, 3'd1, 2'd2, 2'd0, 32'h1111_1111, 32'h2222_2222, 1'b1);
    idle(MULT_N, 1'b1);
    drive(1'b1, 3'd0, 2'd2, 2'd0, 32'hFFFF_FFFD, 32'd5, 1'b0);
    idle(MULT_N + 1, 1'b0);

    // Divides, including the signed overflow corner.
    drive(1'b1, 3'd2, 2'd2, 2'd0, 32'd100, 32'd7, 1'b0);
    idle(DIV_N + 1, 1'b0);
    drive(1'b1, 3'd3, 2'd2, 2'd0, 32'hFFFF_FFF9, 32'd2, 1'b0);
    idle(DIV_N + 1, 1'b0);
    drive(1'b1, 3'd3, 2'd2, 2'd0, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    idle(DIV_N + 1, 1'b0);

    // Divide by zero leaves HI/LO untouched.
    drive(1'b1, 3'd4, 2'd1, 2'd0, 32'h0000_1234, 32'd0, 1'b0);
    drive(1'b1, 3'd4, 2'd0, 2'd0, 32'h0000_5678, 32'd0, 1'b0);
    drive(1'b1, 3'd3, 2'd2, 2'd0, 32'h0000_0042, 32'd0, 1'b0);
    idle(DIV_N + 1, 1'b0);
    drive(1'b1, 3'd2, 2'd2, 2'd1, 32'h0000_0042, 32'd0, 1'b0);
    idle(DIV_N + 1, 1'b0);

    // MTHI then MFHI; MTLO during a busy period; mul_op wins over MT.
    drive(1'b1, 3'd4, 2'd1, 2'd0, 32'hDEAD_BEEF, 32'd0, 1'b0);
    drive(1'b0, 3'd4, 2'd2, 2'd2, 32'd0, 32'd0, 1'b0);
    drive(1'b1, 3'd0, 2'd0, 2'd1, 32'd3, 32'd9, 1'b0);
    drive(1'b1, 3'd4, 2'd0, 2'd1, 32'hCAFE_F00D, 32'd0, 1'b1);
    idle(MULT_N, 1'b0);

    // Back-to-back: next op starts the cycle HI commits, using the forwarded HI.
    drive(1'b1, 3'd1, 2'd2, 2'd0, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b0);
    idle(MULT_N, 1'b0);
    drive(1'b1, 3'd2, 2'd2, 2'd2, m_hi, 32'd3, 1'b1);
    idle(DIV_N + 1, 1'b0);

    // Reset with count=3 mid-MULT discards the result.
    drive(1'b1, 3'd1, 2'd2, 2'd0, 32'd1000, 32'd1000, 1'b0);
    idle(2, 1'b0);
    do_reset();
    idle(MULT_N + 2, 1'b0);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 60) == 0) begin
        do_reset();
      end else begin
        drive($urandom_range(0, 3) != 0,
              ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : 3'd4,
              2'($urandom_range(0, 3)),
              2'($urandom_range(0, 3)),
              pick_operand(), pick_operand(),
              $urandom_range(0, 1) == 1);
      end
    end

    idle(DIV_N + 4, 1'b0);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL queue_drained: got %0d entries left expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mdu_sequencer.md
# mdu_sequencer

Multi-cycle multiply/divide sequencer and HI/LO register owner for the five-stage MIPS pipeline. Accepts MULT/MULTU/DIV/DIVU, MTHI/MTLO and MFHI/MFLO from the E stage using the decoder's `MulOp`/`MTHILO`/`MFHILO` encodings. Models fixed multiply/divide latency with a countdown counter. Raises a stall request so the hazard unit freezes any D-stage HI/LO user until the result is committed.

## Interface
- `MULT_CYCLES`, 5, busy cycles for MULT/MULTU (≥1)
- `DIV_CYCLES`, 10, busy cycles for DIV/DIVU (≥1)

- `clk` in 1: single clock, rising edge
- `reset` in 1: synchronous, active-high
- `issue` in 1: E-stage instruction valid (not bubble/flushed)
- `mul_op` in 3: 000 MULTU, 001 MULT, 010 DIVU, 011 DIV, 100 none; other codes = none
- `mthilo` in 2: 00 MTLO, 01 MTHI, 10/11 none
- `mfhilo` in 2: 01 LO, 10 HI, 00/11 none
- `a`, `b` in 32: forwarded rs/rt values in E
- `d_uses_hilo` in 1: D-stage instruction is any mult/div/MT/MF op
- `start` out 1: comb; `issue` & valid `mul_op` & !`busy`
- `busy` out 1: registered; operation in flight
- `stall_req` out 1: comb; (`busy` | `start`) & `d_uses_hilo`
- `hilo_out` out 32: comb; HI if `mfhilo`=10, LO if 01, else 0
- `hi`, `lo` out 32: current architectural HI/LO

## Operation
- States: IDLE (`count`=0), BUSY (`count`≠0). `count` is 4+ bits wide enough for max parameter.
- IDLE, `start`=1: compute result from `a`,`b` into `pend_hi`/`pend_lo`; load `count` with MULT_CYCLES or DIV_CYCLES; go BUSY. HI/LO unchanged.
- BUSY: `count` decrements each cycle; on the edge where `count` goes 1→0, HI←`pend_hi`, LO←`pend_lo`; return IDLE.
- MULT: signed 32×32→64, HI=[63:32], LO=[31:0]. MULTU: unsigned.
- DIV: LO=signed quotient truncated toward zero, HI=remainder with sign of dividend; 0x80000000 / 0xFFFFFFFF → LO=0x80000000, HI=0. DIVU: unsigned.
- `b`=0 on DIV/DIVU: full busy period still elapses; pending = current HI/LO, so HI/LO unchanged.
- MTHI/MTLO, IDLE, `issue`=1: HI (or LO) ←`a` at edge; `busy` stays 0.
- While BUSY: new `mul_op`, MTHI/MTLO ignored (hazard unit guarantees none arrive; no queueing).
- Same cycle valid `mul_op` and MTHI/MTLO (illegal from decoder): `mul_op` wins, MT dropped.
- `hilo_out` reads architectural HI/LO only; never pending values. MFHI/MFLO is blocked upstream by `stall_req` while busy.
- `issue`=0: all E-stage inputs ignored; in-flight operation continues.
- `reset`: `count`, `busy`, HI, LO, `pend_hi`, `pend_lo` ← 0; in-flight result discarded; takes priority over every other action.

## Timing
- Reset values: `busy`=0, `hi`=0, `lo`=0, `hilo_out`=0, `start`=0 and `stall_req`=0 unless driven by inputs.
- Op issued in cycle T (`start`=1): `busy`=1 in cycles T+1 … T+N; HI/LO new in T+N+1; `busy`=0 in T+N+1.
- A new op may start in T+N+1; its `a`/`b` may come from forwarding of the just-committed HI/LO via MFHI in that cycle.
- `stall_req` high in T (if `d_uses_hilo`) through T+N; low in T+N+1.
- MTHI/MTLO: visible on `hi`/`lo` and `hilo_out` one cycle after issue.
- No combinational path from `a`/`b` to any output.

## Test plan
- Reset: drive `reset` 1 cycle mid-MULT (`count`=3) → next cycle `busy`=0, `hi`=`lo`=0, old result never appears.
- MULT `a`=0xFFFFFFFD, `b`=5, issue at T → `busy` high T+1..T+5; at T+6 `hi`=0xFFFFFFFF, `lo`=0xFFFFFFF1; MULTU same operands → `hi`=0x00000004, `lo`=0xFFFFFFF1.
- DIVU 100/7 → after 10 busy cycles `lo`=14, `hi`=2; DIV 0xFFFFFFF9/2 → `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF; DIV 0x80000000/0xFFFFFFFF → `lo`=0x80000000, `hi`=0.
- Divide by zero with `hi`=0x1234, `lo`=0x5678 → 10 busy cycles, then `hi`/`lo` unchanged.
- MTHI `a`=0xDEADBEEF → next cycle `hi`=0xDEADBEEF, `busy`=0; `mfhilo`=10 → `hilo_out`=0xDEADBEEF; MTLO during BUSY → ignored, `lo` unchanged.
- `d_uses_hilo`=1 throughout a MULT → `stall_req`=1 in T..T+5, 0 at T+6; second MULT issued while busy → ignored, single commit.
